// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand request and result/status bundle for seq_divider.
// master = requester (drives start and operands), slave = the divider.
`timescale 1ns/1ps
interface seq_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// IDLE -> RUN (WIDTH steps) -> DONE (one-cycle done pulse) -> IDLE.
// Optional macro SEQ_DIVIDER_ZERO_CHECK_EN: a zero divisor bypasses RUN and
// reports div_by_zero; otherwise it runs the full algorithm and div_by_zero is 0.
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus_io
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH:0]   r_q, r_d, r_sh;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic             dbz_q;
`endif

  // One restoring step: shift the next dividend bit into r, subtract if it fits.
  always_comb begin
    r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_d  = r_sh;
    q_d  = {q_q[WIDTH-2:0], 1'b0};
    if (r_sh >= {1'b0, dvs_q}) begin
      r_d  = r_sh - {1'b0, dvs_q};
      q_d  = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            dvs_q  <= bus_io.divisor;
            q_q    <= bus_io.dividend;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            if (bus_io.divisor == '0) begin
              // Skip the steps: the answer is already known.
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus_io.dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Final step result goes straight to the outputs so it is valid with done.
            state_q     <= DONE;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d[WIDTH-1:0];
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            dbz_q       <= 1'b0;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.quotient  = quotient_q;
  assign bus_io.remainder = remainder_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign bus_io.div_by_zero = dbz_q;
`else
  assign bus_io.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an
// arithmetic reference (/ and %), including timing, ignored starts and reset.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int W = 4;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_divider_if #(.WIDTH(W)) intf ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus_io(intf.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  // Reference: plain arithmetic, with the natural zero-divisor result.
  function automatic void ref_div(input int a, input int b, output int q, output int r,
                                  output int lat, output int bsy, output int z);
    if (b == 0) begin
      q = (1 << W) - 1; r = a;
      lat = ZC ? 1 : W + 1; bsy = lat; z = ZC ? 1 : 0;
    end else begin
      q = a / b; r = a % b; lat = W + 1; bsy = W + 1; z = 0;
    end
  endfunction

  // Issue one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_op(input int a, input int b, output int lat, output int bcnt,
                       output int q, output int r, output int z);
    @(negedge clk);
    intf.dividend = W'(a); intf.divisor = W'(b); intf.start = 1'b1;
    @(posedge clk); #1;
    intf.start = 1'b0; intf.dividend = W'($urandom); intf.divisor = W'($urandom);
    lat = -1; bcnt = 0; q = 0; r = 0; z = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (intf.busy) bcnt++;
      if (intf.done) begin
        lat = k; q = int'(intf.quotient); r = int'(intf.remainder); z = int'(intf.div_by_zero);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; intf.start = 1'b0; intf.dividend = '0; intf.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (intf.quotient !== '0) begin n_err++; $display("FAIL reset_quotient: got %0d expected 0", intf.quotient); end
    n_cmp++; if (intf.remainder !== '0) begin n_err++; $display("FAIL reset_remainder: got %0d expected 0", intf.remainder); end
    n_cmp++; if (intf.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", intf.busy); end
    n_cmp++; if (intf.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", intf.done); end
    n_cmp++; if (intf.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", intf.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int ta [4] = '{13, 15, 5, 9};
    int tb [4] = '{3, 1, 7, 0};
    int lat, bc, q, r, z, eq, er, el, eb, ez;
    for (int i = 0; i < 4; i++) begin
      ref_div(ta[i], tb[i], eq, er, el, eb, ez);
      do_op(ta[i], tb[i], lat, bc, q, r, z);
      n_cmp++; if (lat !== el) begin n_err++; $display("FAIL dir_latency %0d/%0d: got %0d expected %0d", ta[i], tb[i], lat, el); end
      n_cmp++; if (q !== eq || r !== er) begin n_err++; $display("FAIL dir_result %0d/%0d: got q%0d r%0d expected q%0d r%0d", ta[i], tb[i], q, r, eq, er); end
      n_cmp++; if (z !== ez) begin n_err++; $display("FAIL dir_dbz %0d/%0d: got %0d expected %0d", ta[i], tb[i], z, ez); end
      n_cmp++; if (bc !== eb) begin n_err++; $display("FAIL dir_busy_cycles %0d/%0d: got %0d expected %0d", ta[i], tb[i], bc, eb); end
      @(negedge clk);
      n_cmp++; if (intf.done !== 1'b0 || intf.busy !== 1'b0) begin n_err++; $display("FAIL dir_drop %0d/%0d: got done%b busy%b expected 0 0", ta[i], tb[i], intf.done, intf.busy); end
    end
  endtask

  // Every operand pair in a random order, then extra random operations.
  task automatic test_sweep;
    int order [256];
    int lat, bc, q, r, z, eq, er, el, eb, ez, a, b, j, t;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 300; i++) begin
      if (i < 256) begin a = order[i] >> W; b = order[i] & ((1 << W) - 1); end
      else begin a = int'($urandom_range((1 << W) - 1, 0)); b = int'($urandom_range((1 << W) - 1, 0)); end
      ref_div(a, b, eq, er, el, eb, ez);
      do_op(a, b, lat, bc, q, r, z);
      n_cmp++;
      if (lat !== el || q !== eq || r !== er || z !== ez ||
          (b != 0 && (q * b + r !== a || r >= b))) begin
        n_err++;
        $display("FAIL sweep %0d/%0d: got q%0d r%0d z%0d lat%0d expected q%0d r%0d z%0d lat%0d", a, b, q, r, z, lat, eq, er, ez, el);
      end
    end
  endtask

  // Starts during RUN and DONE are dropped; one right after done is taken.
  task automatic test_ignored_start;
    logic exp_done;
    int eq, er;
    @(negedge clk);
    intf.dividend = 4'd13; intf.divisor = 4'd3; intf.start = 1'b1;
    @(posedge clk); #1 intf.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_done = (k == W + 1) || (k == 2 * W + 3);
      eq = 4; er = (k == W + 1) ? 1 : 0;
      n_cmp++; if (intf.done !== exp_done) begin n_err++; $display("FAIL ign_done cycle %0d: got %b expected %b", k, intf.done, exp_done); end
      if (exp_done) begin
        n_cmp++;
        if (int'(intf.quotient) !== eq || int'(intf.remainder) !== er) begin
          n_err++; $display("FAIL ign_result cycle %0d: got q%0d r%0d expected q%0d r%0d", k, intf.quotient, intf.remainder, eq, er);
        end
      end
      intf.start = (k == 2 || k == W + 1 || k == W + 2);
      intf.dividend = intf.start ? 4'd8 : W'($urandom);
      intf.divisor  = intf.start ? 4'd2 : W'($urandom);
    end
    intf.start = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, bc, q, r, z;
    @(negedge clk);
    intf.dividend = 4'd13; intf.divisor = 4'd3; intf.start = 1'b1;
    @(posedge clk); #1 intf.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (intf.quotient !== '0 || intf.remainder !== '0 || intf.busy !== 1'b0 ||
        intf.done !== 1'b0 || intf.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got q%0d r%0d busy%b done%b dbz%b expected all 0",
                        intf.quotient, intf.remainder, intf.busy, intf.done, intf.div_by_zero);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (intf.done !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_done: got %b expected 0", intf.done); end
    end
    do_op(7, 2, lat, bc, q, r, z);
    n_cmp++; if (lat !== W + 1 || q !== 3 || r !== 1) begin n_err++; $display("FAIL after_reset_op: got q%0d r%0d lat%0d expected q3 r1 lat%0d", q, r, lat, W + 1); end
    // Reset and start together: the start is lost.
    @(negedge clk);
    rst = 1'b1; intf.start = 1'b1; intf.dividend = 4'd13; intf.divisor = 4'd3;
    @(posedge clk); #1 begin rst = 1'b0; intf.start = 1'b0; end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (intf.busy !== 1'b0 || intf.done !== 1'b0) begin n_err++; $display("FAIL rst_start_lost: got busy%b done%b expected 0 0", intf.busy, intf.done); end
    end
  endtask

  task automatic test_hold;
    int lat, bc, q, r, z;
    do_op(14, 4, lat, bc, q, r, z);
    n_cmp++; if (q !== 3 || r !== 2) begin n_err++; $display("FAIL hold_setup: got q%0d r%0d expected q3 r2", q, r); end
    for (int k = 0; k < 10; k++) begin
      intf.start = 1'b0; intf.dividend = W'($urandom); intf.divisor = W'($urandom);
      @(negedge clk);
      n_cmp++;
      if (intf.done !== 1'b0 || int'(intf.quotient) !== 3 || int'(intf.remainder) !== 2) begin
        n_err++; $display("FAIL hold cycle %0d: got done%b q%0d r%0d expected done0 q3 r2", k, intf.done, intf.quotient, intf.remainder);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_sweep;
    test_ignored_start;
    test_reset_mid;
    test_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider: the subtractive counterpart to the team's ripple-carry parallel adder. It computes quotient and remainder of two WIDTH-bit operands by repeated shift-and-subtract, one quotient bit per clock. A single-cycle start/done handshake sequences it, and a busy indication blocks new operations. It sits beside the adder blocks in the arithmetic datapath, where a small-area divide is needed and latency is not critical.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured on accepted start
- divisor  input  WIDTH  denominator; captured on accepted start
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- busy  output  1  high from cycle after accepted start through the done cycle
- done  output  1  single-cycle pulse; results valid from this cycle on
- div_by_zero  output  1  registered; set with done when divisor was 0 (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `start=1` captures the operands, clears the partial remainder and the step counter, and moves to RUN. `start=0` stays in IDLE.
  - RUN: performs one step per cycle. After WIDTH steps it moves to DONE.
  - DONE: asserts `done=1`, loads `quotient`, `remainder` and `div_by_zero`, and returns to IDLE.
- Step rule uses a partial remainder `r` of WIDTH+1 bits and a shift register `q` of WIDTH bits, initially loaded with `dividend`:
  - `r ← {r[WIDTH-1:0], q[WIDTH-1]}`, then `q ← q << 1`.
  - If `r ≥ {0, divisor}`: `r ← r − divisor` and `q[0] ← 1`.
- Final result: `quotient = q`, `remainder = r[WIDTH-1:0]`. Postcondition: `dividend = quotient·divisor + remainder` and `remainder < divisor` for nonzero `divisor`.
- Natural zero-divisor result: `quotient = all ones`, `remainder = dividend`.
- `start` while `busy=1` (RUN or DONE) is ignored; no queuing.
- Operand inputs are don't-care except in the cycle `start` is accepted.
- Outputs hold their last values while IDLE and RUN; they change only in DONE or on reset.

## Timing
- Accepted start at edge E0. RUN steps occupy cycles 1..WIDTH. `done=1` in cycle WIDTH+1. Latency is WIDTH+1 cycles.
- Earliest next accepted start is in the cycle after `done`, giving a throughput of one operation per WIDTH+2 cycles.
- `busy` is high for exactly WIDTH+1 cycles per normal operation and drops in the same cycle `done` drops.
- Reset values: `quotient=0`, `remainder=0`, `busy=0`, `done=0`, `div_by_zero=0`, state IDLE, counter 0.
- Reset mid-operation (RUN or DONE): the block is in IDLE on the next cycle, no `done` pulse is produced, and outputs go to their reset values.
- `rst` and `start` in the same cycle: reset wins and the start is lost.

## Configuration
- Macro: `SEQ_DIVIDER_ZERO_CHECK_EN`.
- Defined:
  - An accepted start with `divisor=0` skips RUN and goes straight to DONE.
  - `done=1` in cycle 1 after E0, and `busy` is high for that one cycle only.
  - `quotient = all ones`, `remainder = dividend`, `div_by_zero=1`.
  - `div_by_zero=0` for every nonzero-divisor result.
- Not defined:
  - A zero divisor runs the full WIDTH steps, with normal latency WIDTH+1, producing the natural result (all ones / `dividend`).
  - `div_by_zero` is tied to 0.

## Test plan
- WIDTH=4, `dividend=13`, `divisor=3`, start pulse → `done` exactly 5 cycles later with `quotient=4`, `remainder=1`. `busy` is high for 5 cycles.
- `15/1` → `quotient=15`, `remainder=0`. `5/7` → `quotient=0`, `remainder=5`. Then an exhaustive 256-pair sweep checks the postcondition.
- `9/0` with the macro defined → `done` after 1 cycle, `quotient=15`, `remainder=9`, `div_by_zero=1`. Without the macro → `done` after 5 cycles, same `quotient`/`remainder`, `div_by_zero=0`.
- Start `13/3`, then pulse start with `8/2` at cycles 2 and 5 (the DONE cycle) → both ignored. The single `done` shows 4 r1. `8/2` issued in the cycle after `done` → 4 r0.
- Assert `rst` in cycle 3 of a `13/3` operation → no `done`, and all outputs are 0 the next cycle. A following `7/2` completes correctly with 3 r1.
- After a result, hold `start=0` for 10 cycles while changing the operand inputs → outputs are unchanged and `done` stays low.
